// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared FSM encoding and line levels for the FIFO-fed UART transmitter
package fifo_uart_tx_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with clear, ticks on the last cycle of each bit
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);
  logic [CNT_WIDTH-1:0] cnt;
  assign bit_tick = cnt == CNT_WIDTH'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else cnt <= (clr || bit_tick) ? '0 : cnt + CNT_WIDTH'(1);
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an async FIFO read port and serialises each word as UART 8N1, LSB first
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int CLKS_PER_BIT    = 16,
  parameter int CNT_WIDTH       = 16,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk_rd,
  input  logic                       rst,
  input  logic                       en_tx,
  input  logic                       empty,
  input  logic [DATA_WIDTH-1:0]      fifo_dout,
  output logic                       en_rd,
  output logic                       tx,
  output logic                       busy,
  output logic                       tx_done,
  output logic [FRAME_CNT_WIDTH-1:0] frames_sent
);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] shift_reg, shift_n;
  logic [IW-1:0] idx, idx_n;
  logic tx_n, bit_tick;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clk(clk_rd),
    .rst(rst),
    .clr(state == IDLE || state == FETCH || state == LOAD),
    .bit_tick(bit_tick)
  );
  assign en_rd   = state == FETCH;
  assign busy    = state != IDLE;
  assign tx_done = state == STOP && bit_tick;
  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    idx_n   = idx;
    unique case (state)
      IDLE:  if (en_tx && !empty) state_n = FETCH;
      FETCH: state_n = LOAD;
      LOAD: begin
        state_n = START;
        shift_n = fifo_dout;
      end
      START: if (bit_tick) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA: if (bit_tick) begin
        shift_n = shift_reg >> 1;
        idx_n   = idx + IW'(1);
        if (idx == IW'(DATA_WIDTH - 1)) state_n = STOP;
      end
      STOP:    if (bit_tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // tx is computed from next state so the flop holds the level for the cycle it applies to
    tx_n = state_n == START ? UART_START_LEVEL : state_n == DATA ? shift_n[0] : UART_IDLE_LEVEL;
  end
  always_ff @(posedge clk_rd or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      idx         <= '0;
      tx          <= UART_IDLE_LEVEL;
      frames_sent <= '0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      idx       <= idx_n;
      tx        <= tx_n;
      if (tx_done) frames_sent <= frames_sent + FRAME_CNT_WIDTH'(1);
    end
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the team's asynchronous FIFO, running entirely in the FIFO read-clock domain.
- Drains bytes from the FIFO using its en_rd/empty/Dout handshake.
- Sends each byte on a UART 8N1 serial line, LSB first.
- Sits between the write-side producer's FIFO and the board TX pin.

Parameters:
- DATA_WIDTH, 8: FIFO word width and UART payload bits per frame.
- CLKS_PER_BIT, 16: clk_rd cycles per serial bit; must be >= 2.
- CNT_WIDTH, 16: width of the bit-period counter; must hold CLKS_PER_BIT-1.
- FRAME_CNT_WIDTH, 16: width of the sent-frame counter.

Ports:
- clk_rd  in  1  single clock; same clock as the FIFO read side.
- rst  in  1  asynchronous active-low reset.
- en_tx  in  1  permission to start new frames; a frame already in flight always completes.
- empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO Dout; valid only in the cycle after an accepted en_rd.
- en_rd  out  1  FIFO read strobe.
- tx  out  1  serial line; idles high.
- busy  out  1  high in any state other than IDLE.
- tx_done  out  1  one-cycle pulse on the last cycle of the stop bit.
- frames_sent  out  FRAME_CNT_WIDTH  count of completed frames; wraps modulo 2^FRAME_CNT_WIDTH.

Behaviour:
- Reset (async, rst low) forces: state=IDLE, tx=1, en_rd=0, busy=0, tx_done=0, frames_sent=0, shift register=0, bit counter=0, bit index=0. Effective immediately, including mid-frame; no partial frame resumes after release.
- en_rd is a pure decode: en_rd = (state==FETCH). No other path drives it.
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP.
  - IDLE: tx=1. If en_tx && !empty, go to FETCH; otherwise stay.
  - FETCH: one cycle, en_rd=1. This block is the only reader, so empty cannot rise between IDLE and FETCH and the read is always accepted. Go to LOAD.
  - LOAD: one cycle. shift_reg <= fifo_dout; this is the exact cycle the FIFO presents the byte. Reads outside this cycle see the FIFO idle value (all ones) and are not sampled. Go to START with bit counter=0.
  - START: tx=0 for CLKS_PER_BIT cycles. Then go to DATA, bit index=0.
  - DATA: tx=shift_reg[0]. Each CLKS_PER_BIT cycles: shift right by one, increment bit index. After DATA_WIDTH bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle: tx_done=1 and frames_sent increments (wrapping). Then go to IDLE.
- Bit timing: the counter runs 0..CLKS_PER_BIT-1 and the period ends when counter==CLKS_PER_BIT-1. Every serial bit is exactly CLKS_PER_BIT cycles.
- Latency: IDLE-with-data to the first tx=0 cycle is 3 clocks (FETCH, LOAD, START begins).
- Back-to-back: minimum gap between a stop-bit end and the next start bit is 3 cycles of tx=1 (IDLE, FETCH, LOAD). The effective stop length is therefore CLKS_PER_BIT+3.
- en_tx deasserted mid-frame: the current frame finishes and the FSM then holds in IDLE. FIFO contents are untouched.
- Empty FIFO: no en_rd pulses are issued and tx stays high indefinitely.
- tx is registered; it is driven from a state/shift-register flop, never combinationally, so the line is glitch-free.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=0, FETCH=1, LOAD=2, START=3, DATA=4, STOP=5, 3 bits.
  - Constants UART_IDLE_LEVEL=1 and UART_START_LEVEL=0.
- One sub-module, uart_bit_timer: counter with clear input, emitting bit_tick when count==CLKS_PER_BIT-1. It is reused by the future receiver.

Test Plan:
- Reset mid-DATA: pull rst low during bit 3 -> tx=1, busy=0, en_rd=0, frames_sent=0 in the same cycle; after release with the FIFO empty, tx stays 1.
- Single byte 0xA5, CLKS_PER_BIT=4, FIFO loaded, en_tx=1:
  - exactly one en_rd pulse;
  - tx low 3 cycles later for 4 cycles;
  - then 1,0,1,0,0,1,0,1 at 4 cycles each;
  - then 4 cycles high with tx_done on the last one;
  - frames_sent=1.
- Back-to-back 0x00, 0xFF:
  - two en_rd pulses, each exactly one cycle;
  - tx high for 4+3 cycles between the two frames;
  - frames_sent=2;
  - no all-ones idle value is ever transmitted as data.
- en_tx dropped during frame 1 of 3 queued bytes -> frame 1 completes, no further en_rd, busy=0; FIFO still reports not-empty with 2 entries. Re-raise en_tx -> the remaining 2 frames are sent in order.
- Empty FIFO with en_tx=1 for 1000 cycles -> en_rd never asserted, tx constant 1, busy=0.
- Counter wrap with FRAME_CNT_WIDTH=2: send 5 frames -> frames_sent reads 1,2,3,0,1 after each tx_done.
